kpn_adder_scheduler: RTL and testbench
======================================

// Module: kpn_adder_scheduler
// PURPOSE
//  Round-robin scheduler sharing one 12.4 fixed-point KPN adder process between NUM_CH channels.
//  Each channel has two input FIFOs and one output FIFO.
//  Pops one token pair from a ready channel, drives adder operands, captures the sum, pushes it to that channel's output FIFO.
//  Sits between the FIFO layer and the single adder instance in the KPN fabric.
// PARAMETERS
//  NUM_CH   2   number of channels (2..8)
//  ADD_LAT  1   adder latency: clocks from add_a/add_b change to add_sum valid (1..4)
//  CW       1   grant index width, >= clog2(NUM_CH)
// PORTS
//  clk       in   1          system clock, all logic on posedge
//  rst       in   1          synchronous, active-high reset
//  in1_empty in   NUM_CH     per-channel empty flag, input FIFO 1
//  in2_empty in   NUM_CH     per-channel empty flag, input FIFO 2
//  out_full  in   NUM_CH     per-channel full flag, output FIFO
//  in1_data  in   NUM_CH*16  FIFO 1 read data; channel c at [16c+15:16c]
//  in2_data  in   NUM_CH*16  FIFO 2 read data, same packing
//  rd        out  NUM_CH     one-hot pop strobe to both input FIFOs of a channel
//  wr        out  NUM_CH     one-hot push strobe to a channel's output FIFO
//  add_a     out  16         adder operand 1 (12-bit integer, 4-bit decimal digit)
//  add_b     out  16         adder operand 2
//  add_sum   in   16         adder result
//  out_data  out  16         data to the output FIFOs (shared bus)
//  busy      out  1          high in every state except IDLE
//  grant_id  out  CW         channel currently served
// BEHAVIOUR
//  Reset: state=IDLE; rd=0, wr=0, add_a=0, add_b=0, out_data=0, busy=0, grant_id=0, rr pointer=NUM_CH-1.
//  Channel c is eligible when in1_empty[c]=0 and in2_empty[c]=0. out_full is not checked at grant.
//  FSM: IDLE -> READ -> CAPT -> WAIT -> WRITE -> IDLE.
//   IDLE : search eligible channels starting at rr+1, wrapping modulo NUM_CH.
//          On the first hit, grant_id<=c and go to READ. No hit: stay in IDLE.
//   READ : rd[c]=1 for exactly 1 cycle. FIFO data is valid the following cycle.
//   CAPT : add_a<=in1_data[c], add_b<=in2_data[c]. Operands are held until the next CAPT.
//   WAIT : ADD_LAT+1 cycles; on the final edge, out_data<=add_sum.
//   WRITE: wr[c]=~out_full[c].
//          out_full[c]=1: stay in WRITE with out_data held, no timeout.
//          Otherwise: one push, rr<=c, go to IDLE.
//  rd and wr are decoded from registered state/grant only; never both high; at most one bit set.
//  Latency with ADD_LAT=1: grant in cycle 0, rd in cycle 1, wr earliest in cycle 5.
//  Minimum period is ADD_LAT+5 cycles per token.
//  No arithmetic is done here; add_sum is passed through unmodified.
//  Input flags changing after grant are ignored until the next IDLE.
//  Only one token is in flight; other channels wait, no starvation.
//  Every eligible channel is served within NUM_CH grants.
//  rst mid-operation:
//   - Token in flight is dropped (already popped; no wr issued).
//   - All outputs return to reset values on the next cycle.
// CONFIGURATION
//  KPN_SCHED_STATS_EN defined:
//   - Adds output tok_count [NUM_CH*16], one 16-bit counter per channel.
//   - Counter increments on each accepted push (wr[c]=1) and wraps 0xFFFF->0x0000.
//   - Cleared by rst.
//  Not defined: port and counters absent; all other behaviour identical.
// TESTING
//  Bench models the adder: add_sum follows add_a+add_b (12.4 decimal-carry) after ADD_LAT clocks.
//  1) ch0 in1=0x0035, in2=0x0047, ch1 empty -> rd[0] in cycle 1; wr[0] in cycle 5; out_data=0x0082.
//  2) Both channels always eligible, 6 tokens -> grant_id sequence 0,1,0,1,0,1; no rd during WRITE.
//  3) out_full[0]=1 for 10 cycles at WRITE -> wr=0 and out_data stable; wr[0] in the cycle after full drops.
//  4) rst in the cycle after rd[0] -> no wr; next cycle all outputs 0; rr restarts at ch0.
//  5) in2_empty[1]=1, in1 of ch1 non-empty -> ch1 never granted; rd[1] stays 0 for 100 cycles.
//  6) STATS_EN, 65537 pushes on ch0 -> tok_count[15:0]=0x0001.

Source files
------------

// File: rtl/kpn_adder_scheduler.sv
// kpn_adder_scheduler
// Round-robin scheduler that time-shares one 12.4 fixed-point KPN adder
// between NUM_CH channels. Each channel has two input FIFOs (operands) and
// one output FIFO (sum). One token pair is in flight at a time.
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | round-robin search for a channel with both input FIFOs non-empty
//   S_READ  | pop strobe (rd) to the granted channel's input FIFOs
//   S_CAPT  | FIFO read data valid; latch adder operands
//   S_WAIT  | ADD_LAT+1 cycles for the adder; sum captured on the final edge
//   S_WRITE | push strobe (wr) to the output FIFO; held off while it is full
//
// rd and wr are registered, so they only ever reflect the registered
// state/grant. wr is decided one edge ahead from the sampled out_full, so a
// full flag that drops in cycle k produces the push in cycle k+1.
//
// Optional feature: define KPN_SCHED_STATS_EN to add o_tok_count, one
// wrapping 16-bit push counter per channel. Without the macro the port and
// counters do not exist and all other behaviour is identical.

module kpn_adder_scheduler #(
    parameter int NUM_CH  = 2,
    parameter int ADD_LAT = 1,
    parameter int CW      = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_CH-1:0]      i_in1_empty,
    input  logic [NUM_CH-1:0]      i_in2_empty,
    input  logic [NUM_CH-1:0]      i_out_full,
    input  logic [NUM_CH*16-1:0]   i_in1_data,
    input  logic [NUM_CH*16-1:0]   i_in2_data,
    output logic [NUM_CH-1:0]      o_rd,
    output logic [NUM_CH-1:0]      o_wr,
    output logic [15:0]            o_add_a,
    output logic [15:0]            o_add_b,
    input  logic [15:0]            i_add_sum,
    output logic [15:0]            o_out_data,
    output logic                   o_busy,
    output logic [CW-1:0]          o_grant_id
`ifdef KPN_SCHED_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]   o_tok_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_grant;
    logic [CW-1:0]       r_rr;
    logic [2:0]          r_wait_cnt;
    logic [NUM_CH-1:0]   r_rd;
    logic [NUM_CH-1:0]   r_wr;
    logic [15:0]         r_add_a;
    logic [15:0]         r_add_b;
    logic [15:0]         r_out_data;

    logic [NUM_CH-1:0]   w_elig;
    logic                w_hit;
    logic [CW-1:0]       w_next;
    logic [NUM_CH-1:0]   w_next_oh;
    logic [NUM_CH-1:0]   w_grant_oh;
    logic [15:0]         w_in1_sel;
    logic [15:0]         w_in2_sel;

    assign w_elig = ~i_in1_empty & ~i_in2_empty;

    // Round-robin search: first eligible channel starting at rr+1, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        w_hit     = 1'b0;
        w_next    = '0;
        w_next_oh = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(r_rr) + k) % NUM_CH;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_hit && (c == idx) && w_elig[c]) begin
                    w_hit        = 1'b1;
                    w_next       = CW'(c);
                    w_next_oh    = '0;
                    w_next_oh[c] = 1'b1;
                end
            end
        end
    end

    // One-hot of the current grant and the granted channel's FIFO read data.
    always_comb begin
        w_grant_oh = '0;
        w_in1_sel  = '0;
        w_in2_sel  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_grant == CW'(c)) begin
                w_grant_oh[c] = 1'b1;
                w_in1_sel     = i_in1_data[c*16 +: 16];
                w_in2_sel     = i_in2_data[c*16 +: 16];
            end
        end
    end

    // Scheduler FSM with registered strobes, operands and result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr       <= CW'(NUM_CH - 1);
            r_wait_cnt <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_out_data <= '0;
        end else begin
            r_rd <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_grant <= w_next;
                        r_rd    <= w_next_oh;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_add_a    <= w_in1_sel;
                    r_add_b    <= w_in2_sel;
                    r_wait_cnt <= 3'(ADD_LAT);
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_out_data <= i_add_sum;
                        r_wr       <= w_grant_oh & ~i_out_full;
                        r_state    <= S_WRITE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                S_WRITE: begin
                    if (|r_wr) begin
                        r_wr    <= '0;
                        r_rr    <= r_grant;
                        r_state <= S_IDLE;
                    end else begin
                        r_wr <= w_grant_oh & ~i_out_full;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rd       = r_rd;
    assign o_wr       = r_wr;
    assign o_add_a    = r_add_a;
    assign o_add_b    = r_add_b;
    assign o_out_data = r_out_data;
    assign o_busy     = (r_state != S_IDLE);
    assign o_grant_id = r_grant;

`ifdef KPN_SCHED_STATS_EN
    logic [15:0] r_tok_count [NUM_CH];

    // Per-channel count of accepted pushes, wrapping at 16 bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_tok_count[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_wr[c]) begin
                    r_tok_count[c] <= r_tok_count[c] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus, channel c at [16c+15:16c].
    always_comb begin
        o_tok_count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_tok_count[c*16 +: 16] = r_tok_count[c];
        end
    end
`endif

endmodule

// File: tb/tb_kpn_adder_scheduler.sv
// Bench for kpn_adder_scheduler (NUM_CH=2, ADD_LAT=1). Models the input
// FIFOs (registered read data), an unbounded output FIFO and a 12.4
// decimal-carry adder with ADD_LAT clocks of latency. Expected sums per
// channel are queued when tokens are pushed and compared at each write.

module tb_kpn_adder_scheduler;

    localparam int NUM_CH  = 2;
    localparam int ADD_LAT = 1;
    localparam int CW      = 1;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    e1;
    logic [NUM_CH-1:0]    e2;
    logic [NUM_CH-1:0]    full;
    logic [NUM_CH*16-1:0] in1_data;
    logic [NUM_CH*16-1:0] in2_data;
    logic [NUM_CH-1:0]    rd;
    logic [NUM_CH-1:0]    wr;
    logic [15:0]          add_a;
    logic [15:0]          add_b;
    logic [15:0]          add_sum;
    logic [15:0]          out_data;
    logic                 busy;
    logic [CW-1:0]        grant_id;
`ifdef KPN_SCHED_STATS_EN
    logic [NUM_CH*16-1:0] tok_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] q1   [NUM_CH][$];
    logic [15:0] q2   [NUM_CH][$];
    logic [15:0] expq [NUM_CH][$];
    logic [15:0] d1   [NUM_CH];
    logic [15:0] d2   [NUM_CH];
    logic [15:0] pipe [ADD_LAT];

    kpn_adder_scheduler #(.NUM_CH(NUM_CH), .ADD_LAT(ADD_LAT), .CW(CW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in1_empty (e1),
        .i_in2_empty (e2),
        .i_out_full  (full),
        .i_in1_data  (in1_data),
        .i_in2_data  (in2_data),
        .o_rd        (rd),
        .o_wr        (wr),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_add_sum   (add_sum),
        .o_out_data  (out_data),
        .o_busy      (busy),
        .o_grant_id  (grant_id)
`ifdef KPN_SCHED_STATS_EN
        ,
        .o_tok_count (tok_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign in1_data = {d1[1], d1[0]};
    assign in2_data = {d2[1], d2[0]};
    assign add_sum  = pipe[ADD_LAT-1];

    // 12.4 addition: low nibble is a decimal digit carrying into the integer part.
    function automatic logic [15:0] dec_add(input logic [15:0] a, input logic [15:0] b);
        int lo;
        int hi;
        int carry;
        lo    = int'(a[3:0]) + int'(b[3:0]);
        carry = (lo >= 10) ? 1 : 0;
        hi    = int'(a[15:4]) + int'(b[15:4]) + carry;
        return {hi[11:0], 4'(lo - carry * 10)};
    endfunction

    function automatic logic [15:0] rand_tok();
        return {12'($urandom_range(0, 4095)), 4'($urandom_range(0, 9))};
    endfunction

    // Input FIFO model: a pop presents the head on the read-data register next cycle.
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd[c] && q1[c].size() > 0 && q2[c].size() > 0) begin
                d1[c] <= q1[c].pop_front();
                d2[c] <= q2[c].pop_front();
                e1[c] <= (q1[c].size() == 0);
                e2[c] <= (q2[c].size() == 0);
            end
        end
    end

    // Adder model with ADD_LAT clocks of latency.
    always @(posedge clk) begin
        pipe[0] <= dec_add(add_a, add_b);
        for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_tok(input int c, input logic [15:0] a, input logic [15:0] b);
        q1[c].push_back(a);
        q2[c].push_back(b);
        expq[c].push_back(dec_add(a, b));
        e1[c] = 1'b0;
        e2[c] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            q1[c].delete();
            q2[c].delete();
            expq[c].delete();
        end
        e1   = '1;
        e2   = '1;
        full = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        e1   = '1;
        e2   = '1;
        full = '0;
        d1[0] = '0; d1[1] = '0; d2[0] = '0; d2[1] = '0;
        cyc();
        cyc();
        n_total++; if (rd !== '0) $display("FAIL reset_rd: got %b want 00", rd); else n_pass++;
        n_total++; if (wr !== '0) $display("FAIL reset_wr: got %b want 00", wr); else n_pass++;
        n_total++; if (add_a !== 16'h0) $display("FAIL reset_add_a: got %h want 0000", add_a); else n_pass++;
        n_total++; if (add_b !== 16'h0) $display("FAIL reset_add_b: got %h want 0000", add_b); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL reset_out_data: got %h want 0000", out_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (grant_id !== '0) $display("FAIL reset_grant: got %0d want 0", grant_id); else n_pass++;
`ifdef KPN_SCHED_STATS_EN
        n_total++; if (tok_count !== '0) $display("FAIL reset_tok_count: got %h want 0", tok_count); else n_pass++;
`endif
        rst = 1'b0;
    endtask

    // Single token on ch0: rd in cycle 1, wr in cycle 5, 0x35+0x47 -> 0x82.
    task automatic test_single();
        logic [1:0] exp_rd;
        logic [1:0] exp_wr;
        do_reset();
        push_tok(0, 16'h0035, 16'h0047);
        for (int n = 1; n <= 6; n++) begin
            cyc();
            exp_rd = (n == 1) ? 2'b01 : 2'b00;
            exp_wr = (n == 5) ? 2'b01 : 2'b00;
            n_total++; if (rd !== exp_rd) $display("FAIL single_rd cycle %0d: got %b want %b", n, rd, exp_rd); else n_pass++;
            n_total++; if (wr !== exp_wr) $display("FAIL single_wr cycle %0d: got %b want %b", n, wr, exp_wr); else n_pass++;
            n_total++; if (busy !== (n <= 5)) $display("FAIL single_busy cycle %0d: got %b want %b", n, busy, (n <= 5)); else n_pass++;
            if (n == 1) begin
                n_total++; if (grant_id !== 1'b0) $display("FAIL single_grant: got %0d want 0", grant_id); else n_pass++;
            end
            if (n == 3) begin
                n_total++; if (add_a !== 16'h0035) $display("FAIL single_add_a: got %h want 0035", add_a); else n_pass++;
                n_total++; if (add_b !== 16'h0047) $display("FAIL single_add_b: got %h want 0047", add_b); else n_pass++;
            end
            if (n == 5) begin
                n_total++; if (out_data !== 16'h0082) $display("FAIL single_out_data: got %h want 0082", out_data); else n_pass++;
                void'(expq[0].pop_front());
            end
        end
    endtask

    // Both channels loaded with 3 tokens each: grants alternate 0,1,0,1,0,1.
    task automatic test_round_robin();
        int k = 0;
        int writes = 0;
        int c;
        logic [15:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_tok(0, rand_tok(), rand_tok());
            push_tok(1, rand_tok(), rand_tok());
        end
        for (int n = 0; n < 100 && writes < 6; n++) begin
            cyc();
            n_total++; if ((rd & wr) !== '0 || (rd != '0 && wr != '0)) $display("FAIL rr_rd_wr_overlap: rd %b wr %b", rd, wr); else n_pass++;
            if (rd != '0) begin
                n_total++; if (grant_id !== CW'(k % 2)) $display("FAIL rr_grant #%0d: got %0d want %0d", k, grant_id, k % 2); else n_pass++;
                n_total++; if (rd !== 2'(1 << (k % 2))) $display("FAIL rr_rd #%0d: got %b want %b", k, rd, 2'(1 << (k % 2))); else n_pass++;
                k++;
            end
            if (wr != '0) begin
                c = wr[1] ? 1 : 0;
                e = (expq[c].size() > 0) ? expq[c].pop_front() : 16'hxxxx;
                n_total++; if (out_data !== e) $display("FAIL rr_data ch%0d: got %h want %h", c, out_data, e); else n_pass++;
                writes++;
            end
        end
        n_total++; if (writes != 6) $display("FAIL rr_write_count: got %0d want 6", writes); else n_pass++;
    endtask

    // Output FIFO full for 10 cycles at WRITE: no push, data held, push the cycle after release.
    task automatic test_backpressure();
        logic [15:0] e;
        do_reset();
        full = 2'b01;
        push_tok(0, rand_tok(), rand_tok());
        e = expq[0][0];
        for (int n = 1; n <= 16; n++) begin
            cyc();
            if (n >= 5 && n <= 14) begin
                n_total++; if (wr !== '0) $display("FAIL bp_wr_while_full cycle %0d: got %b want 00", n, wr); else n_pass++;
                n_total++; if (out_data !== e) $display("FAIL bp_data_hold cycle %0d: got %h want %h", n, out_data, e); else n_pass++;
                if (n == 14) full = 2'b00;
            end
            if (n == 15) begin
                n_total++; if (wr !== 2'b01) $display("FAIL bp_wr_after_release: got %b want 01", wr); else n_pass++;
                n_total++; if (out_data !== e) $display("FAIL bp_data_at_push: got %h want %h", out_data, e); else n_pass++;
                void'(expq[0].pop_front());
            end
            if (n == 16) begin
                n_total++; if (wr !== '0) $display("FAIL bp_single_push: got %b want 00", wr); else n_pass++;
                n_total++; if (busy !== 1'b0) $display("FAIL bp_back_to_idle: got %b want 0", busy); else n_pass++;
            end
        end
    endtask

    // Reset one cycle after rd[0]: token dropped, outputs cleared, rr restarts at ch0.
    task automatic test_reset_midflight();
        int writes = 0;
        int wr_seen = 0;
        int first_grant = -1;
        int c;
        logic [15:0] e;
        do_reset();
        push_tok(0, rand_tok(), rand_tok());
        for (int n = 0; n < 20 && writes < 1; n++) begin
            cyc();
            if (wr == 2'b01) writes++;
        end
        n_total++; if (writes != 1) $display("FAIL mid_warmup_write: got %0d want 1", writes); else n_pass++;
        void'(expq[0].pop_front());
        cyc();
        push_tok(0, 16'h1234, 16'h0567);
        cyc();
        n_total++; if (rd !== 2'b01) $display("FAIL mid_rd: got %b want 01", rd); else n_pass++;
        cyc();
        rst = 1'b1;
        cyc();
        n_total++; if (rd !== '0) $display("FAIL mid_rst_rd: got %b want 00", rd); else n_pass++;
        n_total++; if (wr !== '0) $display("FAIL mid_rst_wr: got %b want 00", wr); else n_pass++;
        n_total++; if (add_a !== 16'h0) $display("FAIL mid_rst_add_a: got %h want 0000", add_a); else n_pass++;
        n_total++; if (add_b !== 16'h0) $display("FAIL mid_rst_add_b: got %h want 0000", add_b); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL mid_rst_out_data: got %h want 0000", out_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (grant_id !== '0) $display("FAIL mid_rst_grant: got %0d want 0", grant_id); else n_pass++;
        rst = 1'b0;
        void'(expq[0].pop_front());
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (wr != '0) wr_seen++;
        end
        n_total++; if (wr_seen != 0) $display("FAIL mid_dropped_token_written: got %0d writes want 0", wr_seen); else n_pass++;
        push_tok(0, rand_tok(), rand_tok());
        push_tok(1, rand_tok(), rand_tok());
        writes = 0;
        for (int n = 0; n < 40 && writes < 2; n++) begin
            cyc();
            if (rd != '0 && first_grant < 0) first_grant = int'(grant_id);
            if (wr != '0) begin
                c = wr[1] ? 1 : 0;
                e = (expq[c].size() > 0) ? expq[c].pop_front() : 16'hxxxx;
                n_total++; if (out_data !== e) $display("FAIL mid_drain_data ch%0d: got %h want %h", c, out_data, e); else n_pass++;
                writes++;
            end
        end
        n_total++; if (first_grant != 0) $display("FAIL mid_rr_restart: got %0d want 0", first_grant); else n_pass++;
        n_total++; if (writes != 2) $display("FAIL mid_drain_count: got %0d want 2", writes); else n_pass++;
    endtask

    // ch1 has only FIFO 1 filled: never granted; ch0 still served.
    task automatic test_half_eligible();
        int rd1_seen = 0;
        int writes0 = 0;
        logic [15:0] e;
        do_reset();
        q1[1].push_back(rand_tok());
        e1[1] = 1'b0;
        push_tok(0, rand_tok(), rand_tok());
        push_tok(0, rand_tok(), rand_tok());
        for (int n = 0; n < 100; n++) begin
            cyc();
            if (rd[1]) rd1_seen++;
            if (wr[1]) rd1_seen++;
            if (wr[0]) begin
                e = (expq[0].size() > 0) ? expq[0].pop_front() : 16'hxxxx;
                n_total++; if (out_data !== e) $display("FAIL half_ch0_data: got %h want %h", out_data, e); else n_pass++;
                writes0++;
            end
        end
        n_total++; if (rd1_seen != 0) $display("FAIL half_ch1_served: got %0d strobes want 0", rd1_seen); else n_pass++;
        n_total++; if (writes0 != 2) $display("FAIL half_ch0_count: got %0d want 2", writes0); else n_pass++;
        q1[1].delete();
        e1[1] = 1'b1;
    endtask

    // Random token arrivals and back-pressure; every push checked against the model.
    task automatic test_random();
        int pushed = 0;
        int writes = 0;
        int bad_strobe = 0;
        int wcnt [NUM_CH];
        int c;
        logic [15:0] e;
        wcnt[0] = 0;
        wcnt[1] = 0;
        do_reset();
        for (int n = 0; n < 3000 && (pushed < 40 || writes < pushed); n++) begin
            cyc();
            if ($countones(rd) > 1 || $countones(wr) > 1 || (rd != '0 && wr != '0)) bad_strobe++;
            if (wr != '0) begin
                c = wr[1] ? 1 : 0;
                e = (expq[c].size() > 0) ? expq[c].pop_front() : 16'hxxxx;
                n_total++; if (out_data !== e) $display("FAIL rand_data ch%0d: got %h want %h", c, out_data, e); else n_pass++;
                writes++;
                wcnt[c]++;
            end
            if (pushed < 40 && $urandom_range(0, 2) == 0) begin
                push_tok(int'($urandom_range(0, 1)), rand_tok(), rand_tok());
                pushed++;
            end
            full = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
        end
        full = '0;
        n_total++; if (writes != pushed) $display("FAIL rand_write_count: got %0d want %0d", writes, pushed); else n_pass++;
        n_total++; if (bad_strobe != 0) $display("FAIL rand_strobe_onehot: got %0d bad cycles want 0", bad_strobe); else n_pass++;
`ifdef KPN_SCHED_STATS_EN
        cyc();
        for (int k = 0; k < NUM_CH; k++) begin
            n_total++;
            if (tok_count[k*16 +: 16] !== 16'(wcnt[k]))
                $display("FAIL rand_tok_count ch%0d: got %0d want %0d", k, tok_count[k*16 +: 16], wcnt[k]);
            else n_pass++;
        end
`endif
    endtask

    initial begin
        rst  = 1'b1;
        e1   = '1;
        e2   = '1;
        full = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_half_eligible();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
